// File: rtl/processador_pkg.sv
// processador_pkg: definitions shared by the processor control unit and its ALU.
//   - data and operand widths
//   - 4-bit opcode constants (ALU operations, memory operations and HALT)
//   - control-unit state enumeration
//   - is_alu_op(): true for opcodes that are executed by the ALU
package processador_pkg;

    localparam int DATA_W = 8;
    localparam int OPER_W = 4;

    localparam logic [3:0] OP_CLR   = 4'b0000;
    localparam logic [3:0] OP_ADD   = 4'b0001;
    localparam logic [3:0] OP_SUB   = 4'b0010;
    localparam logic [3:0] OP_MUL   = 4'b0011;
    localparam logic [3:0] OP_DIV   = 4'b0100;
    localparam logic [3:0] OP_AND   = 4'b0101;
    localparam logic [3:0] OP_OR    = 4'b0110;
    localparam logic [3:0] OP_NOT   = 4'b0111;
    localparam logic [3:0] OP_XOR   = 4'b1000;
    localparam logic [3:0] OP_XNOR  = 4'b1001;
    localparam logic [3:0] OP_PASSA = 4'b1010;
    localparam logic [3:0] OP_PASSB = 4'b1011;
    localparam logic [3:0] OP_STORE = 4'b1100;
    localparam logic [3:0] OP_LOADA = 4'b1101;
    localparam logic [3:0] OP_LOADB = 4'b1110;
    localparam logic [3:0] OP_HALT  = 4'b1111;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_EXEC   = 4'd3,
        S_WB     = 4'd4,
        S_MEM_RD = 4'd5,
        S_MEM_WB = 4'd6,
        S_STORE  = 4'd7,
        S_HALT   = 4'd8
    } estado_t;

    function automatic logic is_alu_op(input logic [3:0] op);
        return (op <= OP_PASSB);
    endfunction

endpackage

// File: rtl/unidade_controle.sv
// unidade_controle: multi-cycle control unit sequencing the 8-bit ALU.
// Fetches instructions from a synchronous ROM, owns registers A/B, drives
// the ALU opcode/enable and moves data between RAM and A/B.
// Ports:
//   clock, reset_n      - clock (rising edge), async active-low reset
//   start               - start execution from PC=0 (only in IDLE/HALT)
//   rom_addr / rom_data - program ROM address (= PC) / instruction (1-cycle latency)
//   ram_addr            - data RAM address (operand of current instruction)
//   ram_wdata / ram_we  - RAM write data / one-cycle write strobe
//   ram_rdata           - RAM read data (1-cycle latency)
//   regA, regB          - register contents (ALU inputs)
//   opcode, operando    - current instruction fields towards the ALU
//   enableULA           - one-cycle ALU enable
//   saidaULA            - registered ALU result
//   ocupado, parado     - busy (outside IDLE/HALT) / halted
//   erro                - sticky divide-by-zero flag
module unidade_controle
    import processador_pkg::*;
#(
    parameter int PC_WIDTH = 4
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                start,
    output logic [PC_WIDTH-1:0] rom_addr,
    input  logic [DATA_W-1:0]   rom_data,
    output logic [OPER_W-1:0]   ram_addr,
    output logic [DATA_W-1:0]   ram_wdata,
    output logic                ram_we,
    input  logic [DATA_W-1:0]   ram_rdata,
    output logic [DATA_W-1:0]   regA,
    output logic [DATA_W-1:0]   regB,
    output logic [3:0]          opcode,
    output logic [OPER_W-1:0]   operando,
    output logic                enableULA,
    input  logic [DATA_W-1:0]   saidaULA,
    output logic                ocupado,
    output logic                parado,
    output logic                erro
);

    estado_t             state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_W-1:0]   ir_q, ir_d;
    logic [DATA_W-1:0]   rega_q, rega_d;
    logic [DATA_W-1:0]   regb_q, regb_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                we_q, we_d;
    logic                en_q, en_d;
    logic                erro_q, erro_d;

    logic [3:0] dec_op;
    logic       div_zero;

    assign dec_op   = rom_data[7:4];
    // regB cannot change between DECODE and WB, so the zero test can be
    // re-evaluated in WB instead of being carried in an extra flag.
    assign div_zero = (ir_q[7:4] == OP_DIV) && (regb_q == '0);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        rega_d  = rega_q;
        regb_d  = regb_q;
        wdata_d = wdata_q;
        erro_d  = erro_q;
        // strobes are one-cycle pulses, asserted on entry to their state
        we_d    = 1'b0;
        en_d    = 1'b0;

        case (state_q)
            S_IDLE, S_HALT: begin
                if (start) begin
                    pc_d    = '0;
                    rega_d  = '0;
                    regb_d  = '0;
                    erro_d  = 1'b0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                ir_d = rom_data;
                pc_d = pc_q + PC_WIDTH'(1);
                if (is_alu_op(dec_op)) begin
                    if ((dec_op == OP_DIV) && (regb_q == '0)) begin
                        state_d = S_WB;
                    end else begin
                        state_d = S_EXEC;
                        en_d    = 1'b1;
                    end
                end else begin
                    case (dec_op)
                        OP_STORE: begin
                            state_d = S_STORE;
                            we_d    = 1'b1;
                            wdata_d = saidaULA;
                        end
                        OP_LOADA, OP_LOADB: state_d = S_MEM_RD;
                        default:            state_d = S_HALT;
                    endcase
                end
            end
            S_EXEC: state_d = S_WB;
            S_WB: begin
                if (div_zero) begin
                    rega_d = '1;
                    erro_d = 1'b1;
                end else begin
                    rega_d = saidaULA;
                end
                state_d = S_FETCH;
            end
            S_MEM_RD: state_d = S_MEM_WB;
            S_MEM_WB: begin
                if (ir_q[7:4] == OP_LOADA) rega_d = ram_rdata;
                else                       regb_d = ram_rdata;
                state_d = S_FETCH;
            end
            S_STORE: state_d = S_FETCH;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
            rega_q  <= '0;
            regb_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            en_q    <= 1'b0;
            erro_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            rega_q  <= rega_d;
            regb_q  <= regb_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            en_q    <= en_d;
            erro_q  <= erro_d;
        end
    end

    assign rom_addr  = pc_q;
    assign ram_addr  = ir_q[3:0];
    assign ram_wdata = wdata_q;
    assign ram_we    = we_q;
    assign regA      = rega_q;
    assign regB      = regb_q;
    assign opcode    = ir_q[7:4];
    assign operando  = ir_q[3:0];
    assign enableULA = en_q;
    assign ocupado   = (state_q != S_IDLE) && (state_q != S_HALT);
    assign parado    = (state_q == S_HALT);
    assign erro      = erro_q;

endmodule

// File: tb/tb_unidade_controle.sv
// tb_unidade_controle: randomized and directed stimulus; an instruction-level
// reference model expands each program into its expected per-cycle output
// trace, which is compared against the DUT every cycle of a run.
module tb_unidade_controle;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] rom_addr, ram_addr, opcode, operando;
    logic [7:0] rom_data, ram_wdata, ram_rdata, regA, regB;
    logic [7:0] saidaULA = 8'h00;
    logic       ram_we, enableULA, ocupado, parado, erro;

    always #5 clock = ~clock;

    unidade_controle #(.PC_WIDTH(4)) dut (
        .clock(clock), .reset_n(reset_n), .start(start),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
        .ram_rdata(ram_rdata), .regA(regA), .regB(regB),
        .opcode(opcode), .operando(operando), .enableULA(enableULA),
        .saidaULA(saidaULA), .ocupado(ocupado), .parado(parado), .erro(erro)
    );

    function automatic logic [7:0] alu(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            4'd0:    return 8'h00;
            4'd1:    return a + b;
            4'd2:    return a - b;
            4'd3:    return a * b;
            4'd4:    return (b == 8'h00) ? 8'hFF : a / b;
            4'd5:    return a & b;
            4'd6:    return a | b;
            4'd7:    return ~a;
            4'd8:    return a ^ b;
            4'd9:    return ~(a ^ b);
            4'd10:   return a;
            4'd11:   return b;
            default: return 8'h00;
        endcase
    endfunction

    // environment: synchronous ROM, synchronous RAM, registered ALU
    logic [7:0] rom [16];
    logic [7:0] ram [16];
    logic [7:0] ram_init [16];
    logic       ram_load = 1'b0;

    always @(posedge clock) rom_data <= rom[rom_addr];
    always @(posedge clock) begin
        if (ram_load) ram <= ram_init;
        else begin
            ram_rdata <= ram[ram_addr];
            if (ram_we) ram[ram_addr] <= ram_wdata;
        end
    end
    always @(posedge clock) if (enableULA) saidaULA <= alu(opcode, regA, regB);

    // per-cycle observation
    typedef struct packed {
        logic [3:0] pc;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] ir;
        logic       en;
        logic       we;
        logic [7:0] wd;
        logic [3:0] raddr;
        logic       ocup;
        logic       par;
        logic       err;
    } obs_t;

    obs_t       exq [$];
    logic [7:0] mram [16];
    logic [7:0] m_S  = 8'h00;
    logic [7:0] m_ir = 8'h00;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [3:0] pc, input logic [7:0] a, input logic [7:0] b,
                        input logic en, input logic we, input logic [7:0] wd,
                        input logic ocup, input logic par, input logic err);
        obs_t o;
        o = '{pc, a, b, m_ir, en, we, wd, m_ir[3:0], ocup, par, err};
        exq.push_back(o);
    endtask

    // Instruction-level execution of the ROM program from PC 0, expanded
    // into the cycle schedule each instruction class takes.
    task automatic build(input int maxcyc);
        logic [3:0] pc, npc, op;
        logic [7:0] a, b, instr;
        logic       err;
        pc = 4'd0; a = 8'h00; b = 8'h00; err = 1'b0;
        while (exq.size() < maxcyc) begin
            instr = rom[pc];
            op    = instr[7:4];
            npc   = pc + 4'd1;
            push(pc, a, b, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, err);   // fetch
            push(pc, a, b, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, err);   // decode
            m_ir = instr;
            if (op <= 4'd11) begin
                if (op == 4'd4 && b == 8'h00) begin
                    push(npc, a, b, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, err);
                    a = 8'hFF; err = 1'b1;
                end else begin
                    push(npc, a, b, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, err);
                    m_S = alu(op, a, b);
                    push(npc, a, b, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, err);
                    a = m_S;
                end
            end else if (op == 4'd12) begin
                push(npc, a, b, 1'b0, 1'b1, m_S, 1'b1, 1'b0, err);
                mram[instr[3:0]] = m_S;
            end else if (op == 4'd13 || op == 4'd14) begin
                push(npc, a, b, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, err);
                push(npc, a, b, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, err);
                if (op == 4'd13) a = mram[instr[3:0]];
                else             b = mram[instr[3:0]];
            end else begin
                repeat (3) push(npc, a, b, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, err);
                break;
            end
            pc = npc;
        end
    endtask

    task automatic commit_ram();
        for (int i = 0; i < 16; i++) mram[i] = ram_init[i];
        @(negedge clock); ram_load = 1'b1;
        @(negedge clock); ram_load = 1'b0;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 16; i++) begin
            rom[i] = 8'h00;
            ram_init[i] = 8'($urandom);
        end
    endtask

    logic [3:0] f_pc;
    logic [7:0] f_a, f_b;
    logic       f_err;
    int         wraps;

    // Start the program, then compare every cycle against the model trace.
    task automatic run_prog(input int maxcyc, input int pulse_at, output int en_cnt, output int halt_idx);
        obs_t e, a;
        logic [3:0] prev_pc;
        exq.delete();
        build(maxcyc);
        en_cnt = 0; halt_idx = -1; wraps = 0; prev_pc = 4'd0;
        @(negedge clock); start = 1'b1;
        @(negedge clock); start = 1'b0;
        for (int i = 0; exq.size() > 0; i++) begin
            e = exq.pop_front();
            a = '{rom_addr, regA, regB, {opcode, operando}, enableULA, ram_we,
                  (e.we ? ram_wdata : 8'h00), ram_addr, ocupado, parado, erro};
            if (i == 0) begin f_pc = rom_addr; f_a = regA; f_b = regB; f_err = erro; end
            total++;
            if (a !== e) begin
                bad++;
                $display("FAIL cycle %0d: got %h want %h", i, a, e);
            end
            if (enableULA) en_cnt++;
            if (parado && halt_idx < 0) halt_idx = i;
            if (i > 0 && prev_pc == 4'd15 && rom_addr == 4'd0) wraps++;
            prev_pc = rom_addr;
            start = (i == pulse_at);
            @(negedge clock);
        end
        start = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clock); reset_n = 1'b0; m_ir = 8'h00;
        @(negedge clock); @(negedge clock); reset_n = 1'b1;
    endtask

    int en_cnt, halt_idx;

    initial begin
        clear_mem();
        #1;
        chk("reset_ctl", 32'({rom_addr, ram_addr, opcode, operando, ram_we, enableULA, ocupado, parado, erro}), 32'h0);
        chk("reset_data", 32'({regA, regB, ram_wdata}), 32'h0);
        @(negedge clock); @(negedge clock); reset_n = 1'b1;
        @(negedge clock);
        chk("idle_after_reset", 32'({ocupado, parado, rom_addr}), 32'h0);

        // LOADA 3; LOADB 4; ADD; STORE 5; HALT
        clear_mem();
        rom[0] = 8'hD3; rom[1] = 8'hE4; rom[2] = 8'h10; rom[3] = 8'hC5; rom[4] = 8'hF0;
        ram_init[3] = 8'h12; ram_init[4] = 8'h05;
        commit_ram();
        run_prog(40, -1, en_cnt, halt_idx);
        chk("model_ram5", 32'(mram[5]), 32'h17);
        chk("p1_ram5", 32'(ram[5]), 32'h17);
        chk("p1_en_once", 32'(en_cnt), 32'd1);
        chk("p1_halt_cycle", 32'(halt_idx), 32'd17);

        // LOADA 0; LOADB 1; DIV with B=0
        clear_mem();
        rom[0] = 8'hD0; rom[1] = 8'hE1; rom[2] = 8'h40; rom[3] = 8'hF0;
        ram_init[0] = 8'h37; ram_init[1] = 8'h00;
        commit_ram();
        run_prog(40, -1, en_cnt, halt_idx);
        chk("div0_regA", 32'(regA), 32'hFF);
        chk("div0_erro", 32'(erro), 32'd1);
        chk("div0_no_en", 32'(en_cnt), 32'd0);

        // SUB 3-5 (restart from HALT also clears erro)
        clear_mem();
        rom[0] = 8'hD0; rom[1] = 8'hE1; rom[2] = 8'h20; rom[3] = 8'hF0;
        ram_init[0] = 8'h03; ram_init[1] = 8'h05;
        commit_ram();
        run_prog(40, -1, en_cnt, halt_idx);
        chk("restart_pc", 32'(f_pc), 32'd0);
        chk("restart_regs", 32'({f_a, f_b}), 32'h0);
        chk("start_clears_erro", 32'(f_err), 32'd0);
        chk("sub_regA", 32'(regA), 32'hFE);

        // MUL 0x20*0x10
        clear_mem();
        rom[0] = 8'hD0; rom[1] = 8'hE1; rom[2] = 8'h30; rom[3] = 8'hF0;
        ram_init[0] = 8'h20; ram_init[1] = 8'h10;
        commit_ram();
        run_prog(40, -1, en_cnt, halt_idx);
        chk("mul_regA", 32'(regA), 32'h00);

        // reset dropped while ram_we is high
        clear_mem();
        rom[0] = 8'hD3; rom[1] = 8'hC5; rom[2] = 8'hF0;
        ram_init[5] = 8'hAA;
        commit_ram();
        @(negedge clock); start = 1'b1;
        @(negedge clock); start = 1'b0;
        for (int k = 0; k < 20 && !ram_we; k++) @(negedge clock);
        chk("store_seen", 32'(ram_we), 32'd1);
        reset_n = 1'b0; m_ir = 8'h00;
        #1;
        chk("async_we_clear", 32'(ram_we), 32'd0);
        chk("midreset_ctl", 32'({rom_addr, ram_addr, opcode, operando, ram_we, enableULA, ocupado, parado, erro}), 32'h0);
        chk("midreset_data", 32'({regA, regB, ram_wdata}), 32'h0);
        @(posedge clock); #1;
        chk("store_aborted", 32'(ram[5]), 32'hAA);
        @(negedge clock); reset_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            chk("stay_idle", 32'({ocupado, parado, rom_addr}), 32'h0);
        end

        // 16 instructions without HALT: PC wraps, mid-run start ignored
        clear_mem();
        for (int i = 0; i < 16; i++) rom[i] = {4'($urandom_range(0, 14)), 4'($urandom)};
        commit_ram();
        run_prog(150, 30, en_cnt, halt_idx);
        chk("pc_wrapped", 32'(wraps > 0), 32'd1);
        do_reset();

        // random programs ending in HALT
        for (int p = 0; p < 15; p++) begin
            int h;
            clear_mem();
            h = $urandom_range(3, 15);
            for (int i = 0; i < 16; i++) begin
                rom[i] = {4'($urandom_range(0, 14)), 4'($urandom)};
                if ($urandom_range(0, 3) == 0) ram_init[i] = 8'h00;
            end
            rom[h] = 8'hF0;
            commit_ram();
            run_prog(200, -1, en_cnt, halt_idx);
            chk("rand_halted", 32'(parado), 32'd1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/unidade_controle.md
# unidade_controle

Multi-cycle control unit that sequences the 8-bit ALU (`ULA`) of the simple processor. It fetches 8-bit instructions from a synchronous program ROM and owns registers A and B. It drives the ALU opcode and enable, and moves data between RAM and the A/B registers. It sits beside `ULA` in the processor top level; the top level instantiates both and wires them together.

## Interface
- `PC_WIDTH`, default 4: program counter width; the ROM holds 2^PC_WIDTH instructions.
- `clock` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: begins execution from PC=0 when in IDLE or HALT.
- `rom_addr` out PC_WIDTH: program ROM address; equals the PC.
- `rom_data` in 8: instruction. Bits [7:4] are the opcode, [3:0] the operand. Valid one cycle after `rom_addr`.
- `ram_addr` out 4: data RAM address; always the operand of the current instruction.
- `ram_wdata` out 8: RAM write data.
- `ram_we` out 1: RAM write strobe, one cycle.
- `ram_rdata` in 8: RAM read data. Valid one cycle after `ram_addr`.
- `regA`, `regB` out 8: register contents; drive the ALU inputs.
- `opcode` out 4: ALU opcode.
- `operando` out 4: ALU operand field.
- `enableULA` out 1: ALU enable, one cycle.
- `saidaULA` in 8: registered ALU result. Updated at the edge on which `enableULA` is sampled high.
- `ocupado` out 1: high outside IDLE and HALT.
- `parado` out 1: high in HALT.
- `erro` out 1: sticky divide-by-zero flag.

## Operation
- Opcodes 0000–1011 are ALU operations: clr, add, sub, mul, div, and, or, not A, xor, xnor, pass A, pass B. The result is written to regA.
- 1100 STORE: RAM[operand] <= saidaULA, the last ALU result.
- 1101 LOADA: regA <= RAM[operand].
- 1110 LOADB: regB <= RAM[operand].
- 1111 HALT.
- State IDLE: waits for `start`. Then PC=0 and the block goes to FETCH.
- State FETCH: presents the PC on `rom_addr`, then goes to DECODE.
- State DECODE: latches `rom_data` into the instruction register and increments the PC. The PC wraps from 2^PC_WIDTH−1 to 0 with no flag. Branches by opcode:
  - ALU opcode → EXEC.
  - 1100 → STORE.
  - 1101 or 1110 → MEM_RD.
  - 1111 → HALT.
- State EXEC: `enableULA`=1 and `opcode` = the instruction opcode, for exactly one cycle. Then WB.
- State WB: regA <= saidaULA, then FETCH.
- Divide by zero: opcode 0100 with regB==0 in DECODE skips EXEC and goes straight to WB. In that case regA <= 8'hFF, `erro` is set, and `enableULA` stays low. `erro` is cleared only by reset or `start`.
- State MEM_RD: `ram_addr` = operand. Then MEM_WB.
- State MEM_WB: regA or regB <= `ram_rdata`, then FETCH.
- State STORE: `ram_we`=1 and `ram_wdata`=saidaULA for one cycle, then FETCH.
- State HALT: `parado`=1. `start` restarts at PC=0 with regA, regB and `erro` cleared.
- `start` while `ocupado` is ignored.
- Arithmetic is done entirely in the ALU; the controller only does the PC increment (mod 2^PC_WIDTH) and the regB zero-compare.

## Timing
- Reset values:
  - State IDLE.
  - PC, instruction register, regA, regB all 0.
  - `rom_addr`, `ram_addr`, `ram_wdata` all 0.
  - `opcode`, `operando` both 0.
  - `ram_we`, `enableULA`, `ocupado`, `parado`, `erro` all 0.
- `ram_we` and `enableULA` are registered outputs. Assertion of `reset_n` low clears them immediately, without waiting for a clock edge, so a write in progress is aborted.
- Latency per instruction, FETCH to the next FETCH:
  - ALU op: 4 cycles (FETCH, DECODE, EXEC, WB).
  - Divide by zero: 3 cycles.
  - LOADA/LOADB: 4 cycles.
  - STORE: 3 cycles.
- regA/regB change only at the WB or MEM_WB edge. ALU inputs are therefore stable while `enableULA` is high.
- `opcode` and `operando` hold the current instruction fields from DECODE until the next DECODE.

## Structure
- Shared package `processador_pkg` holds:
  - The 4-bit opcode constants (OP_CLR … OP_HALT) for both `ULA` and this block.
  - The state enum.
  - The data width (8) and operand width (4).
- Single module. No sub-module: the decode is a case statement inside the FSM.
- `ULA`, the ROM and the RAM are instantiated by the top level, not by this block.

## Test plan
- Reset mid-STORE: drop `reset_n` while `ram_we`=1 → `ram_we` goes to 0 asynchronously, all outputs take their reset values, and the block stays in IDLE until `start`.
- Program LOADA 3; LOADB 4; ADD; STORE 5; HALT with RAM[3]=8'h12 and RAM[4]=8'h05 → RAM[5]=8'h17, `parado`=1 after 4+4+4+3+2 cycles, `enableULA` high exactly once.
- Program LOADA 0; LOADB 1; DIV with RAM[1]=0 → `enableULA` never asserted, regA=8'hFF, `erro`=1. `erro` is cleared by the next `start`.
- SUB with A=8'h03, B=8'h05 → regA=8'hFE (ALU wraps mod 256). MUL with A=8'h20, B=8'h10 → regA=8'h00.
- 16-instruction program with no HALT → `rom_addr` wraps 15→0 and execution continues. Pulse `start` mid-run → ignored, no PC reset.
- `start` asserted in HALT → `rom_addr`=0 in the next FETCH, regA=regB=0.
